branch_target_buffer: RTL and testbench

Parametrised direct-mapped branch target buffer with per-entry saturating direction counters, feeding next-PC selection in the instruction-fetch stage of the pipelined MIPS datapath. Lookup is combinational on the fetch PC. Updates arrive from the execute stage when a branch or jump resolves. A sequenced clear walker invalidates the table one entry per cycle on request, for context switches and self-modifying-code flushes.

---
 rtl/branch_target_buffer.sv | 208 ++++++++++++++++++++
 tb/tb_branch_target_buffer.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_target_buffer.sv
// branch_target_buffer
//   Direct-mapped branch target buffer with per-entry saturating direction
//   counters for next-PC selection in the fetch stage. Lookups are purely
//   combinational on the fetch PC. Resolved branches from execute update the
//   table. A clear walker invalidates one entry per cycle on request.
//
//   Optional feature macro: BTB_STATS_EN
//     When defined, adds stat_updates / stat_mispredicts event counters.
//     When undefined, those ports and registers do not exist.
module branch_target_buffer #(
  parameter int ENTRIES = 16,
  parameter int CTR_W   = 2
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [31:0] lookup_pc,
  output logic        pred_hit,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic [31:0] upd_target,
  input  logic        upd_pred_taken,
  input  logic [31:0] upd_pred_target,
  output logic        mispredict,
  input  logic        clear_req,
  output logic        busy
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_updates,
  output logic [31:0] stat_mispredicts
`endif
);

  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = 30 - IDX_W;

  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(2 ** (CTR_W - 1));
  localparam logic [IDX_W-1:0] PTR_LAST = IDX_W'(ENTRIES - 1);

  typedef enum logic {
    ST_IDLE,
    ST_CLEAR
  } state_t;

  state_t             state_q, state_d;
  logic [IDX_W-1:0]   ptr_q, ptr_d;

  // Table storage: valid bits are reset, payload is not.
  logic [ENTRIES-1:0] valid_q;
  logic [TAG_W-1:0]   tag_q    [ENTRIES];
  logic [31:0]        target_q [ENTRIES];
  logic [CTR_W-1:0]   ctr_q    [ENTRIES];

  // Lookup side decode.
  logic [IDX_W-1:0]   lk_idx;
  logic [TAG_W-1:0]   lk_tag;
  logic               lk_hit;

  // Update side decode and write data.
  logic [IDX_W-1:0]   u_idx;
  logic [TAG_W-1:0]   u_tag;
  logic [CTR_W-1:0]   u_ctr;
  logic               u_hit;
  logic               upd_en;
  logic               clr_en;
  logic               upd_we;
  logic [31:0]        wr_target;
  logic [CTR_W-1:0]   wr_ctr;

  // Word-offset bits of the PCs carry no information for a word-aligned ISA.
  logic unused_pc_bits;
  assign unused_pc_bits = ^{lookup_pc[1:0], upd_pc[1:0]};

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign lk_tag = lookup_pc[31:IDX_W+2];
  assign u_idx  = upd_pc[IDX_W+1:2];
  assign u_tag  = upd_pc[31:IDX_W+2];
  assign u_ctr  = ctr_q[u_idx];
  assign u_hit  = valid_q[u_idx] && (tag_q[u_idx] == u_tag);

  // Mispredict depends only on the resolved instruction, never on the table.
  assign mispredict = upd_valid &&
                      ((upd_pred_taken != upd_taken) ||
                       (upd_taken && (upd_pred_target != upd_target)));

  // FSM state register and clear-walk pointer.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its neighbours; blocking here would create order races.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // FSM next-state: start a walk from IDLE, step the pointer while clearing.
  // NOTE: every combinational output gets a default first, otherwise paths
  // that do not assign it would infer a latch.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE: begin
        if (clear_req) begin
          state_d = ST_CLEAR;
          ptr_d   = '0;
        end
      end
      ST_CLEAR: begin
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == PTR_LAST) begin
          state_d = ST_IDLE;
        end
      end
    endcase
  end

  // FSM outputs: busy while walking; updates only accepted when idle.
  always_comb begin
    busy   = (state_q == ST_CLEAR);
    clr_en = (state_q == ST_CLEAR);
    upd_en = upd_valid && (state_q == ST_IDLE);
  end

  // Update write data: train the counter on a hit, allocate on a taken miss.
  always_comb begin
    upd_we    = 1'b0;
    wr_target = upd_target;
    wr_ctr    = CTR_WEAK;
    if (upd_en) begin
      if (u_hit) begin
        upd_we = 1'b1;
        if (upd_taken) begin
          wr_target = upd_target;
          wr_ctr    = (u_ctr == CTR_MAX) ? u_ctr : u_ctr + CTR_W'(1);
        end else begin
          wr_target = target_q[u_idx];
          wr_ctr    = (u_ctr == '0) ? u_ctr : u_ctr - CTR_W'(1);
        end
      end else if (upd_taken) begin
        upd_we = 1'b1;
      end
    end
  end

  // Valid bits: cleared by reset or the walker, set on allocation.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      valid_q <= '0;
    end else begin
      if (clr_en) begin
        valid_q[ptr_q] <= 1'b0;
      end
      if (upd_we) begin
        valid_q[u_idx] <= 1'b1;
      end
    end
  end

  // Entry payload write.
  // NOTE: the payload array has no reset; a cleared valid bit makes its
  // contents unobservable, so resetting it would only cost flops and routing.
  always_ff @(posedge CLK) begin
    if (upd_we) begin
      tag_q[u_idx]    <= u_tag;
      target_q[u_idx] <= wr_target;
      ctr_q[u_idx]    <= wr_ctr;
    end
  end

  // Combinational lookup from registered state; masked while walking.
  always_comb begin
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag) && !busy;
    pred_hit    = lk_hit;
    pred_taken  = lk_hit && ctr_q[lk_idx][CTR_W-1];
    pred_target = lk_hit ? target_q[lk_idx] : lookup_pc + 32'd4;
  end

`ifdef BTB_STATS_EN
  logic [31:0] stat_updates_q;
  logic [31:0] stat_mispredicts_q;

  // Event counters, live in every FSM state, wrapping modulo 2^32.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stat_updates_q     <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      if (upd_valid) begin
        stat_updates_q <= stat_updates_q + 32'd1;
      end
      if (mispredict) begin
        stat_mispredicts_q <= stat_mispredicts_q + 32'd1;
      end
    end
  end

  assign stat_updates     = stat_updates_q;
  assign stat_mispredicts = stat_mispredicts_q;
`endif

endmodule

// File: tb/tb_branch_target_buffer.sv
// tb_branch_target_buffer
//   Directed vector table, hand-written clear/reset sequences and a random
//   phase checked against a behavioural table model.
module tb_branch_target_buffer;

  localparam int ENTRIES = 16;
  localparam int CTR_MAX = 3;
  localparam int CTR_WEAK = 2;

  logic        CLK = 1'b0;
  logic        nRST;
  logic [31:0] lookup_pc;
  logic        pred_hit;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid;
  logic [31:0] upd_pc;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_pred_taken;
  logic [31:0] upd_pred_target;
  logic        mispredict;
  logic        clear_req;
  logic        busy;
`ifdef BTB_STATS_EN
  logic [31:0] stat_updates;
  logic [31:0] stat_mispredicts;
`endif

  int n_checks = 0;
  int n_errors = 0;

  branch_target_buffer #(.ENTRIES(ENTRIES), .CTR_W(2)) dut (
    .CLK             (CLK),
    .nRST            (nRST),
    .lookup_pc       (lookup_pc),
    .pred_hit        (pred_hit),
    .pred_taken      (pred_taken),
    .pred_target     (pred_target),
    .upd_valid       (upd_valid),
    .upd_pc          (upd_pc),
    .upd_taken       (upd_taken),
    .upd_target      (upd_target),
    .upd_pred_taken  (upd_pred_taken),
    .upd_pred_target (upd_pred_target),
    .mispredict      (mispredict),
    .clear_req       (clear_req),
    .busy            (busy)
`ifdef BTB_STATS_EN
    ,
    .stat_updates    (stat_updates),
    .stat_mispredicts(stat_mispredicts)
`endif
  );

  always #5 CLK = ~CLK;

  // ---------------- behavioural model ----------------
  // Each slot remembers the full PC that owns it; a lookup hits when the
  // owner and the lookup PC agree above the index bits.
  bit          m_valid [ENTRIES];
  logic [31:0] m_owner [ENTRIES];
  logic [31:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_busy;
  logic [31:0] m_upd_cnt;
  logic [31:0] m_mis_cnt;

  function automatic int slot_of(input logic [31:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic bit owns(input logic [31:0] pc);
    int s;
    s = slot_of(pc);
    return m_valid[s] && ((m_owner[s] / (4 * ENTRIES)) == (pc / (4 * ENTRIES)));
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
  endfunction

  function automatic void model_update(input logic [31:0] pc, input bit tk,
                                       input logic [31:0] tgt);
    int s;
    s = slot_of(pc);
    if (owns(pc)) begin
      if (tk) begin
        m_ctr[s] = (m_ctr[s] + 1 > CTR_MAX) ? CTR_MAX : m_ctr[s] + 1;
        m_tgt[s] = tgt;
      end else begin
        m_ctr[s] = (m_ctr[s] - 1 < 0) ? 0 : m_ctr[s] - 1;
      end
    end else if (tk) begin
      m_valid[s] = 1'b1;
      m_owner[s] = pc;
      m_tgt[s]   = tgt;
      m_ctr[s]   = CTR_WEAK;
    end
  endfunction

  function automatic bit exp_mispredict();
    return upd_valid && ((upd_pred_taken != upd_taken) ||
                         (upd_taken && (upd_pred_target != upd_target)));
  endfunction

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  task automatic check_lookup_model(input string tag);
    bit          h;
    logic [31:0] t;
    h = owns(lookup_pc) && (m_busy == 0);
    t = h ? m_tgt[slot_of(lookup_pc)] : lookup_pc + 32'd4;
    check({tag, "_hit"},    32'(pred_hit),   32'(h));
    check({tag, "_taken"},  32'(pred_taken), 32'(h && (m_ctr[slot_of(lookup_pc)] >= 2)));
    check({tag, "_target"}, pred_target,     t);
    check({tag, "_busy"},   32'(busy),       32'(m_busy > 0));
  endtask

  // Advance one clock: inputs are held, model follows what the edge does.
  task automatic tick();
    bit          r, uv, ut, cr, mp;
    logic [31:0] up, ug;
    r = nRST; uv = upd_valid; ut = upd_taken; cr = clear_req;
    up = upd_pc; ug = upd_target; mp = exp_mispredict();
    @(posedge CLK);
    if (!r) begin
      model_clear();
      m_busy    = 0;
      m_upd_cnt = '0;
      m_mis_cnt = '0;
    end else begin
      if (uv) m_upd_cnt = m_upd_cnt + 32'd1;
      if (mp) m_mis_cnt = m_mis_cnt + 32'd1;
      if (m_busy > 0) begin
        m_busy--;
      end else begin
        if (uv) model_update(up, ut, ug);
        if (cr) begin
          m_busy = ENTRIES;
          model_clear();
        end
      end
    end
    @(negedge CLK);
  endtask

  task automatic idle_inputs();
    upd_valid       = 1'b0;
    upd_pc          = '0;
    upd_taken       = 1'b0;
    upd_target      = '0;
    upd_pred_taken  = 1'b0;
    upd_pred_target = '0;
    clear_req       = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    nRST = 1'b0;
    tick();
    tick();
    nRST = 1'b1;
  endtask

  task automatic do_update(input logic [31:0] pc, input bit tk, input logic [31:0] tgt);
    upd_valid = 1'b1; upd_pc = pc; upd_taken = tk; upd_target = tgt;
    tick();
    upd_valid = 1'b0;
  endtask

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [31:0] lk;
    bit          uv;
    logic [31:0] upc;
    bit          utk;
    logic [31:0] utgt;
    bit          e_hit;
    bit          e_taken;
    logic [31:0] e_target;
  } vec_t;

  typedef struct {
    bit          uv;
    bit          ptk;
    bit          tk;
    logic [31:0] ptgt;
    logic [31:0] tgt;
    bit          e_mis;
  } mvec_t;

  vec_t  vecs  [13];
  mvec_t mvecs [6];

  initial begin
    // Outputs are observed before the edge, so an update shows up one row later.
    vecs[0]  = '{32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 32'h44};
    vecs[1]  = '{32'h40, 1, 32'h40, 1, 32'h100, 0, 0, 32'h44};
    vecs[2]  = '{32'h40, 1, 32'h40, 0, 32'h0,   1, 1, 32'h100};
    vecs[3]  = '{32'h40, 1, 32'h40, 0, 32'h0,   1, 0, 32'h100};
    vecs[4]  = '{32'h40, 1, 32'h40, 0, 32'h0,   1, 0, 32'h100};
    vecs[5]  = '{32'h40, 0, 32'h0,  0, 32'h0,   1, 0, 32'h100};
    vecs[6]  = '{32'h40, 1, 32'h80, 1, 32'h200, 1, 0, 32'h100};
    vecs[7]  = '{32'h40, 0, 32'h0,  0, 32'h0,   0, 0, 32'h44};
    vecs[8]  = '{32'h80, 0, 32'h0,  0, 32'h0,   1, 1, 32'h200};
    vecs[9]  = '{32'hFFFF_FFFC, 1, 32'h80, 1, 32'h300, 0, 0, 32'h0};
    vecs[10] = '{32'h80, 1, 32'h80, 0, 32'h999, 1, 1, 32'h300};
    vecs[11] = '{32'h80, 1, 32'h84, 0, 32'h888, 1, 1, 32'h300};
    vecs[12] = '{32'h84, 0, 32'h0,  0, 32'h0,   0, 0, 32'h88};

    mvecs[0] = '{1, 1, 1, 32'h100, 32'h104, 1};
    mvecs[1] = '{1, 1, 1, 32'h100, 32'h100, 0};
    mvecs[2] = '{1, 0, 1, 32'h100, 32'h100, 1};
    mvecs[3] = '{1, 1, 0, 32'h100, 32'h100, 1};
    mvecs[4] = '{1, 0, 0, 32'h100, 32'h200, 0};
    mvecs[5] = '{0, 1, 0, 32'h100, 32'h104, 0};

    lookup_pc = 32'h40;
    do_reset();

    // Reset state.
    check("rst_hit",    32'(pred_hit),   32'h0);
    check("rst_taken",  32'(pred_taken), 32'h0);
    check("rst_target", pred_target,     32'h44);
    check("rst_busy",   32'(busy),       32'h0);

    // Directed training / alias / wrap vectors.
    for (int i = 0; i < 13; i++) begin
      lookup_pc  = vecs[i].lk;
      upd_valid  = vecs[i].uv;
      upd_pc     = vecs[i].upc;
      upd_taken  = vecs[i].utk;
      upd_target = vecs[i].utgt;
      #1;
      check($sformatf("vec%0d_hit", i),    32'(pred_hit),   32'(vecs[i].e_hit));
      check($sformatf("vec%0d_taken", i),  32'(pred_taken), 32'(vecs[i].e_taken));
      check($sformatf("vec%0d_target", i), pred_target,     vecs[i].e_target);
      tick();
    end
    idle_inputs();

    // Mispredict is combinational; no clock edge while these are applied.
    for (int i = 0; i < 6; i++) begin
      upd_valid       = mvecs[i].uv;
      upd_pred_taken  = mvecs[i].ptk;
      upd_taken       = mvecs[i].tk;
      upd_pred_target = mvecs[i].ptgt;
      upd_target      = mvecs[i].tgt;
      upd_pc          = 32'h1000;
      #1;
      check($sformatf("mis%0d", i), 32'(mispredict), 32'(mvecs[i].e_mis));
    end
    idle_inputs();

    // Clear walk: fill, pulse clear_req, count busy cycles with updates and a
    // second clear_req injected mid-walk.
    begin
      int cnt;
      do_reset();
      do_update(32'h10, 1, 32'h110);
      do_update(32'h14, 1, 32'h114);
      do_update(32'h18, 1, 32'h118);
      do_update(32'h1C, 1, 32'h11C);
      lookup_pc = 32'h14;
      #1;
      check("pre_clear_hit", 32'(pred_hit), 32'h1);
      clear_req = 1'b1;
      #1;
      check("clear_accept_busy", 32'(busy), 32'h0);
      tick();
      clear_req = 1'b0;
      cnt = 0;
      upd_valid = 1'b1; upd_pc = 32'h20; upd_taken = 1'b1; upd_target = 32'h500;
      lookup_pc = 32'h10;
      while (busy === 1'b1 && cnt < 40) begin
        #1;
        check("walk_hit",    32'(pred_hit),    32'h0);
        check("walk_target", pred_target,      32'h14);
        clear_req = (cnt == 3);
        tick();
        cnt++;
      end
      idle_inputs();
      check("walk_len", cnt, ENTRIES);
      for (int i = 0; i < 5; i++) begin
        lookup_pc = 32'h10 + 32'(4 * i);
        #1;
        check($sformatf("post_walk_hit%0d", i), 32'(pred_hit), 32'h0);
      end
    end

    // Reset during a walk aborts it and leaves the table invalid.
    do_reset();
    do_update(32'h3C, 1, 32'h33C);
    do_update(32'h38, 1, 32'h338);
    clear_req = 1'b1;
    tick();
    clear_req = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    check("mid_walk_busy", 32'(busy), 32'h1);
    nRST = 1'b0;
    tick();
    check("abort_busy", 32'(busy), 32'h0);
    nRST = 1'b1;
    lookup_pc = 32'h3C;
    #1;
    check("abort_hit_3c", 32'(pred_hit), 32'h0);
    lookup_pc = 32'h38;
    #1;
    check("abort_hit_38", 32'(pred_hit), 32'h0);
    check("abort_tgt_38", pred_target,   32'h3C);

`ifdef BTB_STATS_EN
    // Ten updates, three of them mispredicted.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      upd_valid       = 1'b1;
      upd_pc          = 32'(i * 4);
      upd_taken       = 1'b1;
      upd_pred_taken  = 1'b1;
      upd_target      = 32'h700;
      upd_pred_target = (i < 3) ? 32'h704 : 32'h700;
      tick();
    end
    idle_inputs();
    check("stat_updates",     stat_updates,     32'd10);
    check("stat_mispredicts", stat_mispredicts, 32'd3);
    force dut.stat_updates_q = 32'hFFFF_FFFF;
    #1;
    release dut.stat_updates_q;
    check("stat_preload", stat_updates, 32'hFFFF_FFFF);
    do_update(32'h40, 0, 32'h0);
    check("stat_wrap", stat_updates, 32'h0);
`endif

    // Random phase against the model.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      logic [31:0] tags [4];
      logic [31:0] pc_l, pc_u;
      tags[0] = 32'h0; tags[1] = 32'h1; tags[2] = 32'h2; tags[3] = 32'h03FF_FFFF;
      pc_l = (tags[$urandom_range(0, 3)] << 6) | (32'($urandom_range(0, 15)) << 2);
      pc_u = (tags[$urandom_range(0, 3)] << 6) | (32'($urandom_range(0, 15)) << 2);
      lookup_pc       = pc_l;
      upd_valid       = ($urandom_range(0, 3) != 0);
      upd_pc          = pc_u;
      upd_taken       = $urandom_range(0, 1) == 1;
      upd_target      = $urandom & 32'hFFFF_FFFC;
      upd_pred_taken  = $urandom_range(0, 1) == 1;
      upd_pred_target = ($urandom_range(0, 1) == 1) ? upd_target : ($urandom & 32'hFFFF_FFFC);
      clear_req       = ($urandom_range(0, 99) == 0);
      #1;
      check_lookup_model("rnd");
      check("rnd_mispredict", 32'(mispredict), 32'(exp_mispredict()));
`ifdef BTB_STATS_EN
      check("rnd_stat_upd", stat_updates,     m_upd_cnt);
      check("rnd_stat_mis", stat_mispredicts, m_mis_cnt);
`endif
      tick();
    end
    idle_inputs();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
